// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// error pulses and a selectable first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH:0]   r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags decode the registered count only, so they never glitch
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    // Next-state for pointers, occupancy and the error pulses
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        ovf_d   = w_en && full;
        udf_d   = r_en && empty;
        if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
        if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents survive reset and are simply abandoned
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[w_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem_q[r_ptr_q[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            assign dout_d = rd_acc ? mem_q[r_ptr_q[ADDR_WIDTH-1:0]] : dout_q;

            // Registered read port; holds when no read is accepted
            always_ff @(posedge clk or posedge rst) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: standard-mode instance driven
// by vector table and scoreboard, plus a small FWFT instance.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0, r_en = 1'b0;
    logic [7:0] data_in = '0, data_out;
    logic       full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    logic       w1 = 1'b0, r1 = 1'b0;
    logic [7:0] d1 = '0, q1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] cnt1;

    int nchk = 0;
    int nerr = 0;
    int m_cnt = 0;
    logic [7:0] m_dout = '0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in),
        .r_en(r_en), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(afull), .almost_empty(aempty), .count(count),
        .overflow(ovf), .underflow(udf)
    );

    sync_fifo_param #(.FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .w_en(w1), .data_in(d1),
        .r_en(r1), .data_out(q1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock of stimulus on dut0 with full model/scoreboard check
    task automatic cyc(input logic we, input logic [7:0] wd,
                       input logic re);
        logic wa, ra;
        logic e_ovf, e_udf;
        wa    = we && (m_cnt != 16);
        ra    = re && (m_cnt != 0);
        e_ovf = we && (m_cnt == 16);
        e_udf = re && (m_cnt == 0);
        w_en = we;
        data_in = wd;
        r_en = re;
        @(posedge clk);
        #1;
        if (ra) m_dout = sb.pop_front();
        if (wa) sb.push_back(wd);
        m_cnt = m_cnt + int'(wa) - int'(ra);
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == 16));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(afull), 32'(m_cnt >= 12));
        chk("almost_empty", 32'(aempty), 32'(m_cnt <= 4));
        chk("overflow", 32'(ovf), 32'(e_ovf));
        chk("underflow", 32'(udf), 32'(e_udf));
        chk("data_out", 32'(data_out), 32'(m_dout));
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        int         cnt;
        logic [7:0] dout;
        logic       udf;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int maxc;

        tbl[0] = '{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 1, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 8'h22, 1'b0, 2, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 2, 8'h11, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 8'h22, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 8'h33, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 8'h33, 1'b1};

        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_dout", 32'(data_out), 0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].we, tbl[i].wd, tbl[i].re);
            chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
            chk("tbl_dout", 32'(data_out), 32'(tbl[i].dout));
            chk("tbl_udf", 32'(udf), 32'(tbl[i].udf));
        end
        cyc(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            chk("fill_afull", 32'(afull), 32'(i + 1 >= 12));
            chk("fill_aempty", 32'(aempty), 32'(i + 1 <= 4));
        end
        chk("fill_full", 32'(full), 1);
        cyc(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 16);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(ovf), 0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(data_out), 32'(i));
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_pulse", 32'(udf), 1);
        chk("udf_hold", 32'(data_out), 32'h0F);
        cyc(1'b0, 8'h00, 1'b0);
        chk("udf_clear", 32'(udf), 0);

        d = 8'h40;
        maxc = 0;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k <= i % 4; k++) begin
                cyc(1'b1, d, 1'b0);
                d++;
                if (int'(count) > maxc) maxc = int'(count);
            end
            for (int k = 0; k <= i % 4; k++) cyc(1'b0, 8'h00, 1'b1);
        end
        chk("wrap_max", 32'(maxc), 4);
        chk("wrap_empty", 32'(empty), 1);

        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, d, 1'b0);
            d++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, d, 1'b1);
            d++;
            chk("simul_count", 32'(count), 8);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, d, 1'b0);
            d++;
        end
        cyc(1'b1, 8'hEE, 1'b1);
        chk("full_rw_count", 32'(count), 15);
        chk("full_rw_ovf", 32'(ovf), 1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("full_rw_empty", 32'(empty), 1);

        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        chk("pre_rst_count", 32'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_dout", 32'(data_out), 0);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_dout = '0;
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_read", 32'(data_out), 32'h77);

        w1 = 1'b1;
        d1 = 8'h5A;
        @(posedge clk);
        #1;
        w1 = 1'b0;
        chk("fwft_empty", 32'(empty1), 0);
        chk("fwft_dout", 32'(q1), 32'h5A);
        @(posedge clk);
        #1;
        chk("fwft_hold", 32'(q1), 32'h5A);
        r1 = 1'b1;
        @(posedge clk);
        #1;
        r1 = 1'b0;
        chk("fwft_pop_empty", 32'(empty1), 1);
        w1 = 1'b1;
        d1 = 8'h11;
        @(posedge clk);
        #1;
        d1 = 8'h22;
        @(posedge clk);
        #1;
        w1 = 1'b0;
        chk("fwft_head", 32'(q1), 32'h11);
        r1 = 1'b1;
        @(posedge clk);
        #1;
        r1 = 1'b0;
        chk("fwft_next", 32'(q1), 32'h22);
        chk("fwft_cnt", 32'(cnt1), 1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
